alu_issue_arbiter: RTL and testbench

- Shares the single integer ALU (decoder plus execute unit) between two requesters: port 0 is the main pipeline EX stage, port 1 is the address-generation/branch helper.
- Round-robin arbitration over valid/ready requests.
- Registers the winning request into an issue stage that drives the ALU decode inputs and operands, and returns a tagged registered response.
- Owns the ALU clock-gate enable: gates after a programmable idle window and sequences wake-up before issuing.

---
 rtl/alu_issue_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-port issue arbiter in front of the shared integer ALU: round-robin grant,
// registered issue stage, tagged response and idle clock gating.
// Build option: define ALU_ARB_FIXED_PRIO_EN for strict port-0 priority.
module alu_issue_arbiter #(
    parameter int DATA_W    = 32,
    parameter int IDLE_HOLD = 4,
    parameter int WAKE_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [6:0]        req0_opcode,
    input  logic [2:0]        req0_funct3,
    input  logic [6:0]        req0_funct7,
    input  logic [DATA_W-1:0] req0_op_a,
    input  logic [DATA_W-1:0] req0_op_b,
    input  logic [6:0]        req1_opcode,
    input  logic [2:0]        req1_funct3,
    input  logic [6:0]        req1_funct7,
    input  logic [DATA_W-1:0] req1_op_a,
    input  logic [DATA_W-1:0] req1_op_b,
    output logic [6:0]        alu_opcode,
    output logic [2:0]        alu_funct3,
    output logic [6:0]        alu_funct7,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              alu_clk_en
);
    localparam int IDLE_W = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
    localparam int WAKE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

    typedef enum logic [1:0] {
        GATED  = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
    logic [WAKE_W-1:0]   wake_cnt, wake_cnt_d;
    logic                grant_id;
    logic                accept;
    logic                idle;
    logic                issue_vld_p1;
    logic                issue_id_p1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                last_grant;
`endif

    // Grant: only in ACTIVE, one-hot to the winning valid port.
    always_comb begin
        req_ready = 2'b00;
        grant_id  = 1'b0;
        if (state_q == ACTIVE) begin
            case (req_valid)
                2'b01: begin
                    grant_id  = 1'b0;
                    req_ready = 2'b01;
                end
                2'b10: begin
                    grant_id  = 1'b1;
                    req_ready = 2'b10;
                end
                2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    grant_id  = 1'b0;
`else
                    grant_id  = ~last_grant;
`endif
                    req_ready = grant_id ? 2'b10 : 2'b01;
                end
                default: begin
                    grant_id  = 1'b0;
                    req_ready = 2'b00;
                end
            endcase
        end
    end

    assign accept = |(req_valid & req_ready);
    assign idle   = (req_valid == 2'b00) && !issue_vld_p1 && !rsp_valid;

    // A request in the expiring idle cycle makes idle false, so gating is cancelled.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            GATED: begin
                if (req_valid != 2'b00) state_d = WAKE;
            end
            WAKE: begin
                if (wake_cnt == WAKE_W'(WAKE_LAT - 1)) state_d = ACTIVE;
                else wake_cnt_d = wake_cnt + 1'b1;
            end
            ACTIVE: begin
                if (idle) begin
                    if (idle_cnt == IDLE_W'(IDLE_HOLD - 1)) state_d = GATED;
                    else idle_cnt_d = idle_cnt + 1'b1;
                end
            end
            default: state_d = GATED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GATED;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            alu_clk_en   <= 1'b0;
            issue_vld_p1 <= 1'b0;
            rsp_valid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt     <= idle_cnt_d;
            wake_cnt     <= wake_cnt_d;
            alu_clk_en   <= (state_d != GATED);
            issue_vld_p1 <= accept;
            rsp_valid    <= issue_vld_p1;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) last_grant <= 1'b1;
        else if (accept) last_grant <= grant_id;
    end
`endif

    // Stage p1: issue registers feeding the ALU; stage p2: response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= '0;
            alu_op_a    <= '0;
            alu_op_b    <= '0;
            issue_id_p1 <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
        end else begin
            if (accept) begin
                alu_opcode  <= grant_id ? req1_opcode : req0_opcode;
                alu_funct3  <= grant_id ? req1_funct3 : req0_funct3;
                alu_funct7  <= grant_id ? req1_funct7 : req0_funct7;
                alu_op_a    <= grant_id ? req1_op_a   : req0_op_a;
                alu_op_b    <= grant_id ? req1_op_b   : req0_op_b;
                issue_id_p1 <= grant_id;
            end
            rsp_id     <= issue_id_p1;
            rsp_result <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomised and directed bench for alu_issue_arbiter against a cycle-stamped
// scoreboard model of grant order, response timing and clock gating.
`timescale 1ns/1ps
module tb_alu_issue_arbiter;
    localparam int DW = 32;
    localparam int IH = 4;
    localparam int WL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready;
    logic [6:0]    req0_opcode, req1_opcode, req0_funct7, req1_funct7;
    logic [2:0]    req0_funct3, req1_funct3;
    logic [DW-1:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [6:0]    alu_opcode, alu_funct7;
    logic [2:0]    alu_funct3;
    logic [DW-1:0] alu_op_a, alu_op_b, alu_result, rsp_result;
    logic          rsp_valid, rsp_id, alu_clk_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.DATA_W(DW), .IDLE_HOLD(IH), .WAKE_LAT(WL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_opcode(req0_opcode), .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_opcode(req1_opcode), .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .alu_clk_en(alu_clk_en)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (f3)
            3'd0:    return (op == 7'b0110011 && f7 == 7'b0100000) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_funct3, alu_funct7, alu_op_a, alu_op_b);

    // Reference model: cycle-stamped expectations; cyc is the index of the current cycle.
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] res;
    } rsp_t;

    rsp_t q[$];
    int   cyc         = 0;
    bit   m_on        = 1'b0;
    int   m_act_at    = 0;
    int   m_last_busy = 0;
    int   m_last      = 1;

    function automatic int m_winner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        return -1;
    endfunction

    function automatic logic [1:0] m_ready();
        int w;
        w = m_winner(req_valid);
        if (!(m_on && cyc >= m_act_at) || w < 0) return 2'b00;
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int m_rsp_idx();
        foreach (q[i]) if (q[i].due == cyc) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit busy;
        if (rst) begin
            m_on   = 1'b0;
            m_last = 1;
            q.delete();
        end else if (!m_on) begin
            if (req_valid != 2'b00) begin
                m_on        = 1'b1;
                m_act_at    = cyc + 1 + WL;
                m_last_busy = m_act_at - 1;
            end
        end else if (cyc >= m_act_at) begin
            busy = (req_valid != 2'b00);
            foreach (q[i]) if (q[i].due == cyc || q[i].due == cyc + 1) busy = 1'b1;
            w = m_winner(req_valid);
            if (w == 0)
                q.push_back('{due: cyc + 2, id: 1'b0,
                              res: alu_fn(req0_opcode, req0_funct3, req0_funct7, req0_op_a, req0_op_b)});
            if (w == 1)
                q.push_back('{due: cyc + 2, id: 1'b1,
                              res: alu_fn(req1_opcode, req1_funct3, req1_funct7, req1_op_a, req1_op_b)});
            if (w >= 0) m_last = w;
            if (busy) m_last_busy = cyc;
            else if (cyc - m_last_busy >= IH) m_on = 1'b0;
        end
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        cyc++;
    end

    task automatic new_payload(input int p);
        logic [6:0] op, f7;
        logic [2:0] f3;
        case ($urandom_range(0, 4))
            0:       f3 = 3'd0;
            1:       f3 = 3'd1;
            2:       f3 = 3'd4;
            3:       f3 = 3'd6;
            default: f3 = 3'd7;
        endcase
        op = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
        f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        if (p == 0) begin
            req0_opcode = op; req0_funct3 = f3; req0_funct7 = f7;
            req0_op_a = $urandom; req0_op_b = $urandom;
        end else begin
            req1_opcode = op; req1_funct3 = f3; req1_funct7 = f7;
            req1_op_a = $urandom; req1_op_b = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_id !== 1'b0 || rsp_result !== '0) begin bad++; $display("FAIL reset_rsp got id=%b res=%h exp 0/0", rsp_id, rsp_result); end
        total++; if ({alu_opcode, alu_funct3, alu_funct7} !== 17'd0) begin bad++; $display("FAIL reset_alu_dec got=%h exp=0", {alu_opcode, alu_funct3, alu_funct7}); end
        total++; if (alu_op_a !== '0 || alu_op_b !== '0) begin bad++; $display("FAIL reset_alu_ops got a=%h b=%h exp 0", alu_op_a, alu_op_b); end
        total++; if (alu_clk_en !== 1'b0) begin bad++; $display("FAIL reset_clk_en got=%b exp=0", alu_clk_en); end
        @(negedge clk);
    endtask

    task automatic test_first_request();
        logic [1:0]    acc;
        int            k;
        int            acc_at = -1;
        int            rsp_at = -1;
        logic          rid = 1'b1;
        logic [DW-1:0] rres = '0;
        req0_opcode = 7'b0110011; req0_funct3 = 3'd0; req0_funct7 = 7'b0100000;
        req0_op_a = 32'd10; req0_op_b = 32'd3;
        req_valid = 2'b01;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL first_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL first_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            k = m_rsp_idx();
            total++;
            if (rsp_valid !== (k >= 0)) begin bad++; $display("FAIL first_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (k >= 0)); end
            acc = req_valid & req_ready;
            if (acc[0] && acc_at < 0) acc_at = i;
            if (rsp_valid === 1'b1 && rsp_at < 0) begin rsp_at = i; rid = rsp_id; rres = rsp_result; end
            @(negedge clk);
            req_valid = req_valid & ~acc;
        end
        total++; if (acc_at != 1 + WL) begin bad++; $display("FAIL first_accept_cycle got=%0d exp=%0d", acc_at, 1 + WL); end
        total++; if (rsp_at != acc_at + 2) begin bad++; $display("FAIL first_rsp_cycle got=%0d exp=%0d", rsp_at, acc_at + 2); end
        total++; if (rid !== 1'b0 || rres !== 32'd7) begin bad++; $display("FAIL first_rsp_data got id=%b res=%0d exp id=0 res=7", rid, rres); end
    endtask

    task automatic test_round_robin();
        logic [1:0] acc;
        int         k;
        logic       g_id[6];
        logic       r_id[6];
        int         gcyc[6];
        int         rcyc[6];
        int         ng = 0, nr = 0, issued = 2;
        logic       e;
        rst = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        new_payload(0); new_payload(1);
        req_valid = 2'b11;
        for (int i = 0; i < 40 && nr < 6; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL rr_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            k = m_rsp_idx();
            total++;
            if (rsp_valid !== (k >= 0)) begin bad++; $display("FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (k >= 0)); end
            else if (k >= 0) begin
                total++;
                if (rsp_id !== q[k].id || rsp_result !== q[k].res) begin bad++; $display("FAIL rr_rsp_data cyc=%0d got %b/%h exp %b/%h", cyc, rsp_id, rsp_result, q[k].id, q[k].res); end
            end
            acc = req_valid & req_ready;
            if (acc != 2'b00 && ng < 6) begin g_id[ng] = acc[1]; gcyc[ng] = i; ng++; end
            if (rsp_valid === 1'b1 && nr < 6) begin r_id[nr] = rsp_id; rcyc[nr] = i; nr++; end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    if (issued < 6) begin new_payload(p); issued++; end
                    else req_valid[p] = 1'b0;
                end
            end
        end
        total++; if (ng != 6 || nr != 6) begin bad++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 6/6", ng, nr); end
        for (int j = 0; j < ng && j < nr; j++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e = (j < 5) ? 1'b0 : 1'b1;
`else
            e = 1'(j % 2);
`endif
            total++; if (g_id[j] !== e) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", j, g_id[j], e); end
            total++; if (gcyc[j] != gcyc[0] + j) begin bad++; $display("FAIL rr_b2b_%0d got=%0d exp=%0d", j, gcyc[j], gcyc[0] + j); end
            total++;
            if (r_id[j] !== g_id[j] || rcyc[j] != gcyc[j] + 2) begin bad++; $display("FAIL rr_order_%0d got id=%b cyc=%0d exp id=%b cyc=%0d", j, r_id[j], rcyc[j], g_id[j], gcyc[j] + 2); end
        end
    endtask

    task automatic test_idle_gating();
        logic [1:0] acc;
        int         k;
        int         fall = -1, drop = -1, acc_at = -1;
        req_valid = 2'b00;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL idle_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            k = m_rsp_idx();
            total++; if (rsp_valid !== (k >= 0)) begin bad++; $display("FAIL idle_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (k >= 0)); end
            if (rsp_valid === 1'b0 && fall < 0) fall = i;
            if (alu_clk_en === 1'b0 && drop < 0) drop = i;
            @(negedge clk);
        end
        total++; if (fall < 0 || drop - fall != IH) begin bad++; $display("FAIL idle_gate_delay got=%0d exp=%0d", drop - fall, IH); end
        new_payload(1);
        req_valid = 2'b10;
        for (int i = 0; i < 8 && acc_at < 0; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL idle_wake_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL idle_wake_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            acc = req_valid & req_ready;
            if (acc[1]) acc_at = i;
            @(negedge clk);
            req_valid = req_valid & ~acc;
        end
        total++; if (acc_at != 1 + WL) begin bad++; $display("FAIL idle_wake_accept got=%0d exp=%0d", acc_at, 1 + WL); end
    endtask

    task automatic test_idle_cancel();
        logic [1:0] acc;
        int         k;
        bit         saw = 1'b0, fired = 1'b0;
        int         quiet = 0, fire_i = -1, drops = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL cancel_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL cancel_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            k = m_rsp_idx();
            total++;
            if (rsp_valid !== (k >= 0)) begin bad++; $display("FAIL cancel_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (k >= 0)); end
            else if (k >= 0) begin
                total++;
                if (rsp_id !== q[k].id || rsp_result !== q[k].res) begin bad++; $display("FAIL cancel_rsp_data cyc=%0d got %b/%h exp %b/%h", cyc, rsp_id, rsp_result, q[k].id, q[k].res); end
            end
            if (fired && i == fire_i) begin
                total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL cancel_same_cycle_accept got=%b exp=01", req_ready); end
            end
            if (fired && i >= fire_i && i <= fire_i + 3 && alu_clk_en !== 1'b1) drops++;
            acc = req_valid & req_ready;
            if (rsp_valid === 1'b1) saw = 1'b1;
            else if (saw && !fired) quiet++;
            @(negedge clk);
            req_valid = req_valid & ~acc;
            if (quiet == IH - 1 && !fired) begin
                new_payload(0);
                req_valid = 2'b01;
                fired = 1'b1;
                fire_i = i + 1;
            end
        end
        total++; if (!fired || drops != 0) begin bad++; $display("FAIL cancel_clk_en_held got fired=%b drops=%0d exp fired=1 drops=0", fired, drops); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] acc;
        bit         got = 1'b0;
        int         errs = 0;
        new_payload(0);
        req_valid = 2'b01;
        for (int i = 0; i < 12 && !got; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rstmid_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            acc = req_valid & req_ready;
            got = acc[0];
            @(negedge clk);
            req_valid = req_valid & ~acc;
        end
        total++; if (!got) begin bad++; $display("FAIL rstmid_accept_timeout got=0 exp=1"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rsp_valid !== 1'b0 || alu_clk_en !== 1'b0 || req_ready !== 2'b00) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rstmid_dropped got bad_cycles=%0d exp=0", errs); end
    endtask

    task automatic test_random();
        logic [1:0] acc;
        int         k;
        bit         busy;
        for (int i = 0; i < 600; i++) begin
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready()); end
            total++; if (alu_clk_en !== m_on) begin bad++; $display("FAIL rand_clk_en cyc=%0d got=%b exp=%b", cyc, alu_clk_en, m_on); end
            k = m_rsp_idx();
            total++;
            if (rsp_valid !== (k >= 0)) begin bad++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (k >= 0)); end
            else if (k >= 0) begin
                total++;
                if (rsp_id !== q[k].id || rsp_result !== q[k].res) begin bad++; $display("FAIL rand_rsp_data cyc=%0d got %b/%h exp %b/%h", cyc, rsp_id, rsp_result, q[k].id, q[k].res); end
            end
            acc = req_valid & req_ready;
            @(negedge clk);
            busy = ((i / 60) % 2) == 0;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) req_valid[p] = 1'b0;
                if (!req_valid[p] && $urandom_range(0, 99) < (busy ? 60 : 4)) begin
                    new_payload(p);
                    req_valid[p] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req0_opcode = '0; req0_funct3 = '0; req0_funct7 = '0; req0_op_a = '0; req0_op_b = '0;
        req1_opcode = '0; req1_funct3 = '0; req1_funct7 = '0; req1_op_a = '0; req1_op_b = '0;
        test_reset();
        test_first_request();
        test_round_robin();
        test_idle_gating();
        test_idle_cancel();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
